// File: rtl/cfoc_cfg_sequencer.sv
// cfoc_cfg_sequencer
// Sits between the input pipeline FIFO and the CFOC core. It holds the CFOC
// runtime config (NPER, NITER, SEL_OUT) stable while frames are inside the
// core. Host config writes are staged, the core is drained, and the new
// config is applied only once the core is empty. Frames in flight are
// counted, and new input frames are throttled at frame boundaries.
//
// Ports
//   ap_clk, ap_rst_n          clock, asynchronous active-low reset
//   cfg_stb, cfg_*            1-cycle strobe that stages a new config (last write wins)
//   s_t*                      upstream sample stream (frame ends on s_tlast)
//   m_t*                      stream to CFOC i_data (zero-latency passthrough, gated)
//   mon_t*                    snoop of CFOC o_data handshake (observe only)
//   NPER, NITER, SEL_OUT      active config driven to CFOC
//   cfg_busy                  staged config pending, not yet applied
//   inflight                  frames admitted to CFOC and not yet seen at its output
//   frame_cnt                 completed output frames (wraps)
//   err_underrun              sticky: output tlast seen with inflight == 0
module cfoc_cfg_sequencer #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MAX_INFLIGHT = 4,
  parameter int unsigned CNT_W        = 16,
  parameter logic [7:0]  DEF_NPER     = 8'd16,
  parameter logic [15:0] DEF_NITER    = 16'd1,
  parameter logic [1:0]  DEF_SELOUT   = 2'd0
) (
  input  logic                                 ap_clk,
  input  logic                                 ap_rst_n,
  input  logic                                 cfg_stb,
  input  logic [7:0]                           cfg_nper,
  input  logic [15:0]                          cfg_niter,
  input  logic [1:0]                           cfg_selout,
  input  logic [DATA_W-1:0]                    s_tdata,
  input  logic                                 s_tvalid,
  input  logic                                 s_tlast,
  output logic                                 s_tready,
  output logic [DATA_W-1:0]                    m_tdata,
  output logic                                 m_tvalid,
  output logic                                 m_tlast,
  input  logic                                 m_tready,
  input  logic                                 mon_tvalid,
  input  logic                                 mon_tready,
  input  logic                                 mon_tlast,
  output logic [7:0]                           NPER,
  output logic [15:0]                          NITER,
  output logic [1:0]                           SEL_OUT,
  output logic                                 cfg_busy,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]    inflight,
  output logic [CNT_W-1:0]                     frame_cnt,
  output logic                                 err_underrun
);

  localparam int unsigned IF_W = $clog2(MAX_INFLIGHT + 1);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_APPLY = 2'd2;

  logic [1:0]       state, state_nxt;
  logic             gate, gate_nxt;
  logic             in_frame, in_frame_nxt;
  logic [7:0]       sh_nper, sh_nper_nxt;
  logic [15:0]      sh_niter, sh_niter_nxt;
  logic [1:0]       sh_selout, sh_selout_nxt;
  logic [7:0]       nper_nxt;
  logic [15:0]      niter_nxt;
  logic [1:0]       selout_nxt;
  logic             cfg_busy_nxt;
  logic [IF_W-1:0]  inflight_nxt;
  logic [CNT_W-1:0] frame_cnt_nxt;
  logic             err_nxt;

  logic acc;
  logic in_last;
  logic out_last;

  // Zero-latency passthrough; the gate only withholds handshakes.
  assign m_tdata  = s_tdata;
  assign m_tlast  = s_tlast;
  assign m_tvalid = s_tvalid & gate;
  assign s_tready = m_tready & gate;

  assign acc      = s_tvalid & m_tready & gate;
  assign in_last  = acc & s_tlast;
  assign out_last = mon_tvalid & mon_tready & mon_tlast;

  // Next-state logic: frame tracking, counters, config staging and FSM.
  always_comb begin
    state_nxt     = state;
    in_frame_nxt  = in_frame;
    sh_nper_nxt   = sh_nper;
    sh_niter_nxt  = sh_niter;
    sh_selout_nxt = sh_selout;
    nper_nxt      = NPER;
    niter_nxt     = NITER;
    selout_nxt    = SEL_OUT;
    cfg_busy_nxt  = cfg_busy;
    inflight_nxt  = inflight;
    frame_cnt_nxt = frame_cnt;
    err_nxt       = err_underrun;
    gate_nxt      = 1'b0;

    if (acc) begin
      in_frame_nxt = ~s_tlast;
    end

    // Simultaneous admit and completion cancel out.
    if (in_last && !out_last) begin
      inflight_nxt = inflight + IF_W'(1);
    end else if (out_last && !in_last) begin
      if (inflight == '0) begin
        err_nxt = 1'b1;
      end else begin
        inflight_nxt = inflight - IF_W'(1);
      end
    end

    if (out_last) begin
      frame_cnt_nxt = frame_cnt + CNT_W'(1);
    end

    case (state)
      ST_RUN: begin
        if (cfg_busy && !in_frame && !acc) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (inflight == '0) begin
          state_nxt = ST_APPLY;
        end
      end
      ST_APPLY: begin
        nper_nxt     = sh_nper;
        niter_nxt    = sh_niter;
        selout_nxt   = sh_selout;
        cfg_busy_nxt = 1'b0;
        state_nxt    = ST_RUN;
      end
      default: begin
        state_nxt = ST_RUN;
      end
    endcase

    // A strobe in any state (APPLY included) restages and re-pends.
    if (cfg_stb) begin
      sh_nper_nxt   = cfg_nper;
      sh_niter_nxt  = cfg_niter;
      sh_selout_nxt = cfg_selout;
      cfg_busy_nxt  = 1'b1;
    end

    // Gate is computed from next-state values so that it always matches the
    // registered state it guards; an open frame always keeps it open.
    gate_nxt = in_frame_nxt |
               ((state_nxt == ST_RUN) &&
                (inflight_nxt < IF_W'(MAX_INFLIGHT)) &&
                !cfg_busy_nxt);
  end

  // State and output registers.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state        <= ST_RUN;
      gate         <= 1'b0;
      in_frame     <= 1'b0;
      sh_nper      <= DEF_NPER;
      sh_niter     <= DEF_NITER;
      sh_selout    <= DEF_SELOUT;
      NPER         <= DEF_NPER;
      NITER        <= DEF_NITER;
      SEL_OUT      <= DEF_SELOUT;
      cfg_busy     <= 1'b0;
      inflight     <= '0;
      frame_cnt    <= '0;
      err_underrun <= 1'b0;
    end else begin
      state        <= state_nxt;
      gate         <= gate_nxt;
      in_frame     <= in_frame_nxt;
      sh_nper      <= sh_nper_nxt;
      sh_niter     <= sh_niter_nxt;
      sh_selout    <= sh_selout_nxt;
      NPER         <= nper_nxt;
      NITER        <= niter_nxt;
      SEL_OUT      <= selout_nxt;
      cfg_busy     <= cfg_busy_nxt;
      inflight     <= inflight_nxt;
      frame_cnt    <= frame_cnt_nxt;
      err_underrun <= err_nxt;
    end
  end

endmodule

// File: tb/tb_cfoc_cfg_sequencer.sv
// Testbench for cfoc_cfg_sequencer: directed vector table, hand-written
// multi-cycle sequences, and randomized stimulus against a frame-level model.
module tb_cfoc_cfg_sequencer;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned MAX_INF = 4;
  // Narrow counter so the wrap is reached in a short random run.
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned IF_W    = $clog2(MAX_INF + 1);

  logic              ap_clk;
  logic              ap_rst_n;
  logic              cfg_stb;
  logic [7:0]        cfg_nper;
  logic [15:0]       cfg_niter;
  logic [1:0]        cfg_selout;
  logic [DATA_W-1:0] s_tdata;
  logic              s_tvalid;
  logic              s_tlast;
  logic              s_tready;
  logic [DATA_W-1:0] m_tdata;
  logic              m_tvalid;
  logic              m_tlast;
  logic              m_tready;
  logic              mon_tvalid;
  logic              mon_tready;
  logic              mon_tlast;
  logic [7:0]        NPER;
  logic [15:0]       NITER;
  logic [1:0]        SEL_OUT;
  logic              cfg_busy;
  logic [IF_W-1:0]   inflight;
  logic [CNT_W-1:0]  frame_cnt;
  logic              err_underrun;

  cfoc_cfg_sequencer #(
    .DATA_W(DATA_W), .MAX_INFLIGHT(MAX_INF), .CNT_W(CNT_W),
    .DEF_NPER(8'd16), .DEF_NITER(16'd1), .DEF_SELOUT(2'd0)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .cfg_stb(cfg_stb), .cfg_nper(cfg_nper), .cfg_niter(cfg_niter), .cfg_selout(cfg_selout),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .mon_tvalid(mon_tvalid), .mon_tready(mon_tready), .mon_tlast(mon_tlast),
    .NPER(NPER), .NITER(NITER), .SEL_OUT(SEL_OUT), .cfg_busy(cfg_busy),
    .inflight(inflight), .frame_cnt(frame_cnt), .err_underrun(err_underrun)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  int checks = 0;
  int errors = 0;
  int max_inf_seen = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  // phase: 0 = admitting, 1 = waiting for the core to empty, 2 = applying.
  int         m_inflight, m_cnt, m_phase;
  bit         m_err, m_in_frame, m_busy, m_first;
  logic [7:0]  m_nper,  m_sh_nper;
  logic [15:0] m_niter, m_sh_niter;
  logic [1:0]  m_sel,   m_sh_sel;

  task automatic model_reset();
    m_inflight = 0; m_cnt = 0; m_phase = 0;
    m_err = 0; m_in_frame = 0; m_busy = 0; m_first = 1;
    m_nper = 8'd16; m_niter = 16'd1; m_sel = 2'd0;
    m_sh_nper = 8'd16; m_sh_niter = 16'd1; m_sh_sel = 2'd0;
  endtask

  function automatic bit m_gate();
    if (m_first) return 1'b0;
    return m_in_frame || (m_phase == 0 && m_inflight < int'(MAX_INF) && !m_busy);
  endfunction

  task automatic model_compare();
    bit g;
    g = m_gate();
    chk("s_tready",     64'(s_tready),     64'(m_tready & g));
    chk("m_tvalid",     64'(m_tvalid),     64'(s_tvalid & g));
    chk("m_tdata",      64'(m_tdata),      64'(s_tdata));
    chk("m_tlast",      64'(m_tlast),      64'(s_tlast));
    chk("NPER",         64'(NPER),         64'(m_nper));
    chk("NITER",        64'(NITER),        64'(m_niter));
    chk("SEL_OUT",      64'(SEL_OUT),      64'(m_sel));
    chk("cfg_busy",     64'(cfg_busy),     64'(m_busy));
    chk("inflight",     64'(inflight),     64'(m_inflight));
    chk("frame_cnt",    64'(frame_cnt),    64'(m_cnt));
    chk("err_underrun", 64'(err_underrun), 64'(m_err));
    if (int'(inflight) > max_inf_seen) max_inf_seen = int'(inflight);
  endtask

  task automatic model_step();
    bit admit, fin, done_out, was_in_frame, was_busy;
    int old_inf, old_phase;
    admit        = s_tvalid && m_tready && m_gate();
    fin          = admit && s_tlast;
    done_out     = mon_tvalid && mon_tready && mon_tlast;
    was_in_frame = m_in_frame;
    was_busy     = m_busy;
    old_inf      = m_inflight;
    old_phase    = m_phase;

    if (fin && !done_out) m_inflight = old_inf + 1;
    else if (done_out && !fin) begin
      if (old_inf == 0) m_err = 1;
      else m_inflight = old_inf - 1;
    end
    if (done_out) m_cnt = (m_cnt + 1) % (1 << CNT_W);
    if (admit) m_in_frame = !s_tlast;

    if (old_phase == 0 && was_busy && !was_in_frame && !admit) m_phase = 1;
    else if (old_phase == 1 && old_inf == 0) m_phase = 2;
    else if (old_phase == 2) begin
      m_phase = 0;
      m_nper = m_sh_nper; m_niter = m_sh_niter; m_sel = m_sh_sel;
      m_busy = 0;
    end
    if (cfg_stb) begin
      m_sh_nper = cfg_nper; m_sh_niter = cfg_niter; m_sh_sel = cfg_selout;
      m_busy = 1;
    end
    m_first = 0;
  endtask

  // Called at a negedge: compare, advance the model, land just after posedge.
  task automatic tick();
    model_compare();
    model_step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic cycle();
    @(negedge ap_clk);
    tick();
  endtask

  task automatic set_mon(input bit v);
    mon_tvalid = v; mon_tready = v; mon_tlast = v;
  endtask

  task automatic mon_pulse();
    set_mon(1'b1);
    cycle();
    set_mon(1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_s_tready"},  64'(s_tready),     64'(0));
    chk({tag, "_m_tvalid"},  64'(m_tvalid),     64'(0));
    chk({tag, "_NPER"},      64'(NPER),         64'(16));
    chk({tag, "_NITER"},     64'(NITER),        64'(1));
    chk({tag, "_SEL_OUT"},   64'(SEL_OUT),      64'(0));
    chk({tag, "_cfg_busy"},  64'(cfg_busy),     64'(0));
    chk({tag, "_inflight"},  64'(inflight),     64'(0));
    chk({tag, "_frame_cnt"}, 64'(frame_cnt),    64'(0));
    chk({tag, "_err"},       64'(err_underrun), 64'(0));
  endtask

  // Entered just after a posedge; leaves reset released mid-cycle.
  task automatic apply_reset();
    s_tvalid = 1'b1; m_tready = 1'b1;
    ap_rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_values("rst");
    repeat (2) @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
    s_tvalid = 1'b0;
  endtask

  // Sends one frame of len beats with random data; bounded wait per beat.
  task automatic send_frame(input int len, input int budget, output int stalls);
    logic [DATA_W-1:0] d;
    bit done;
    int w;
    stalls = 0;
    for (int b = 0; b < len; b++) begin
      d = $urandom();
      s_tdata = d; s_tvalid = 1'b1; s_tlast = (b == len - 1);
      done = 0; w = 0;
      while (!done) begin
        @(negedge ap_clk);
        if (s_tready) begin
          chk("pt_data", 64'(m_tdata), 64'(d));
          chk("pt_last", 64'(m_tlast), 64'(b == len - 1));
          done = 1;
        end else begin
          stalls++;
        end
        tick();
        if (!done) begin
          w++;
          if (w >= budget) begin
            checks++; errors++;
            $display("FAIL send_timeout beat=%0d actual=stalled required=accepted", b);
            s_tvalid = 1'b0; s_tlast = 1'b0;
            return;
          end
        end
      end
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  typedef struct {
    int sv, sl, mr, mon, stb, nper;
    int e_rdy, e_inf, e_cnt, e_err, e_nper, e_busy;
  } vec_t;

  vec_t tbl[14];

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, total;

    ap_rst_n = 1'b0; cfg_stb = 1'b0; cfg_nper = '0; cfg_niter = '0; cfg_selout = '0;
    s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b0;
    set_mon(1'b0);
    model_reset();

    //                sv sl mr mon stb nper | rdy inf cnt err nper busy
    tbl[0]  = '{1, 0, 1, 0, 0, 0,   0, 0, 0, 0, 16, 0};  // first cycle after release: gate shut
    tbl[1]  = '{1, 0, 1, 0, 0, 0,   1, 0, 0, 0, 16, 0};
    tbl[2]  = '{1, 1, 1, 0, 0, 0,   1, 0, 0, 0, 16, 0};
    tbl[3]  = '{1, 1, 1, 1, 0, 0,   1, 1, 0, 0, 16, 0};  // admit + complete together
    tbl[4]  = '{0, 0, 1, 1, 0, 0,   1, 1, 1, 0, 16, 0};
    tbl[5]  = '{0, 0, 1, 1, 0, 0,   1, 0, 2, 0, 16, 0};  // completion at zero: underrun
    tbl[6]  = '{0, 0, 1, 0, 0, 0,   1, 0, 3, 1, 16, 0};
    tbl[7]  = '{0, 0, 1, 0, 1, 32,  1, 0, 3, 1, 16, 0};
    tbl[8]  = '{1, 1, 1, 0, 0, 0,   0, 0, 3, 1, 16, 1};
    tbl[9]  = '{1, 1, 1, 0, 0, 0,   0, 0, 3, 1, 16, 1};
    tbl[10] = '{1, 1, 1, 0, 0, 0,   0, 0, 3, 1, 16, 1};
    tbl[11] = '{1, 1, 1, 0, 0, 0,   1, 0, 3, 1, 32, 0};
    tbl[12] = '{0, 0, 1, 1, 0, 0,   1, 1, 3, 1, 32, 0};
    tbl[13] = '{0, 0, 1, 0, 0, 0,   1, 0, 4, 1, 32, 0};

    @(posedge ap_clk);
    #1;

    // Reset hold with traffic offered, then the vector table.
    apply_reset();
    for (int i = 0; i < 14; i++) begin
      s_tvalid = (tbl[i].sv != 0); s_tlast = (tbl[i].sl != 0);
      m_tready = (tbl[i].mr != 0); set_mon(tbl[i].mon != 0);
      s_tdata = $urandom();
      cfg_stb = (tbl[i].stb != 0); cfg_nper = 8'(tbl[i].nper);
      cfg_niter = 16'd5; cfg_selout = 2'd2;
      @(negedge ap_clk);
      chk($sformatf("tbl%0d_s_tready", i), 64'(s_tready), 64'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d_m_tvalid", i), 64'(m_tvalid), 64'(tbl[i].e_rdy & tbl[i].sv));
      chk($sformatf("tbl%0d_inflight", i), 64'(inflight), 64'(tbl[i].e_inf));
      chk($sformatf("tbl%0d_frame_cnt", i), 64'(frame_cnt), 64'(tbl[i].e_cnt));
      chk($sformatf("tbl%0d_err", i), 64'(err_underrun), 64'(tbl[i].e_err));
      chk($sformatf("tbl%0d_NPER", i), 64'(NPER), 64'(tbl[i].e_nper));
      chk($sformatf("tbl%0d_busy", i), 64'(cfg_busy), 64'(tbl[i].e_busy));
      tick();
    end
    cfg_stb = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; set_mon(1'b0);
    chk("tbl_NITER_applied", 64'(NITER), 64'(5));
    chk("tbl_SEL_OUT_applied", 64'(SEL_OUT), 64'(2));

    // Passthrough: three 8-beat frames with no stalls.
    apply_reset();
    cycle();
    total = 0;
    for (int f = 0; f < 3; f++) begin
      send_frame(8, 20, st);
      total += st;
      chk("t2_inflight", 64'(inflight), 64'(f + 1));
    end
    chk("t2_stalls", 64'(total), 64'(0));

    // Throttle: fifth frame held until one completion.
    apply_reset();
    cycle();
    max_inf_seen = 0;
    for (int f = 0; f < 4; f++) send_frame(4, 20, st);
    chk("t3_inflight_full", 64'(inflight), 64'(4));
    s_tvalid = 1'b1; s_tlast = 1'b0; s_tdata = $urandom();
    for (int c = 0; c < 6; c++) begin
      @(negedge ap_clk);
      chk("t3_held", 64'(s_tready), 64'(0));
      tick();
    end
    set_mon(1'b1);
    @(negedge ap_clk);
    chk("t3_held_mon", 64'(s_tready), 64'(0));
    tick();
    set_mon(1'b0);
    send_frame(4, 5, st);
    chk("t3_admit_stalls", 64'(st), 64'(0));
    chk("t3_inflight_after", 64'(inflight), 64'(4));
    chk("t3_frame_cnt", 64'(frame_cnt), 64'(1));
    chk("t3_max_inflight", 64'(max_inf_seen), 64'(4));

    // Config mid-frame: frame finishes, core drains, then config applies.
    repeat (3) mon_pulse();
    chk("t4_inflight_start", 64'(inflight), 64'(1));
    cfg_nper = 8'd32; cfg_niter = 16'd9; cfg_selout = 2'd1;
    for (int b = 0; b < 8; b++) begin
      s_tvalid = 1'b1; s_tlast = (b == 7); s_tdata = $urandom();
      cfg_stb = (b == 3);
      @(negedge ap_clk);
      chk("t4_nosplit", 64'(s_tready), 64'(1));
      if (b == 4) begin
        chk("t4_busy_set", 64'(cfg_busy), 64'(1));
        chk("t4_nper_hold", 64'(NPER), 64'(16));
      end
      tick();
    end
    cfg_stb = 1'b0;
    s_tvalid = 1'b1; s_tlast = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge ap_clk);
      chk("t4_gate_closed", 64'(s_tready), 64'(0));
      chk("t4_nper_16", 64'(NPER), 64'(16));
      chk("t4_inflight2", 64'(inflight), 64'(2));
      tick();
    end
    mon_pulse();
    for (int c = 0; c < 3; c++) begin
      @(negedge ap_clk);
      chk("t4_gate_closed1", 64'(s_tready), 64'(0));
      chk("t4_nper_16b", 64'(NPER), 64'(16));
      tick();
    end
    mon_pulse();
    @(negedge ap_clk);
    chk("t4_drain_nper", 64'(NPER), 64'(16));
    chk("t4_drain_ready", 64'(s_tready), 64'(0));
    tick();
    @(negedge ap_clk);
    chk("t4_apply_nper", 64'(NPER), 64'(16));
    chk("t4_apply_busy", 64'(cfg_busy), 64'(1));
    tick();
    @(negedge ap_clk);
    chk("t4_new_nper", 64'(NPER), 64'(32));
    chk("t4_new_niter", 64'(NITER), 64'(9));
    chk("t4_new_sel", 64'(SEL_OUT), 64'(1));
    chk("t4_busy_clear", 64'(cfg_busy), 64'(0));
    chk("t4_reopen", 64'(s_tready), 64'(1));
    tick();
    s_tvalid = 1'b0; s_tlast = 1'b0;
    chk("t4_inflight_end", 64'(inflight), 64'(1));

    // Async reset while draining.
    cfg_stb = 1'b1; cfg_nper = 8'd64; cfg_niter = 16'd7; cfg_selout = 2'd3;
    cycle();
    cfg_stb = 1'b0;
    repeat (2) cycle();
    chk("t6_busy_before", 64'(cfg_busy), 64'(1));
    s_tvalid = 1'b1;
    #3;
    ap_rst_n = 1'b0;
    #1;
    check_reset_values("t6");
    model_reset();
    repeat (2) @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
    s_tvalid = 1'b0;
    repeat (5) cycle();
    chk("t6_discard_nper", 64'(NPER), 64'(16));
    chk("t6_discard_busy", 64'(cfg_busy), 64'(0));

    // Randomized traffic against the model.
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      s_tvalid   = ($urandom_range(99) < 70);
      s_tlast    = ($urandom_range(99) < 25);
      s_tdata    = $urandom();
      m_tready   = ($urandom_range(99) < 80);
      mon_tvalid = ($urandom_range(99) < 50);
      mon_tready = ($urandom_range(99) < 60);
      mon_tlast  = ($urandom_range(99) < 40);
      cfg_stb    = ($urandom_range(99) < 3);
      cfg_nper   = 8'($urandom());
      cfg_niter  = 16'($urandom());
      cfg_selout = 2'($urandom());
      cycle();
    end
    cfg_stb = 1'b0; s_tvalid = 1'b0; set_mon(1'b0);
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
